vec_ram_reader: RTL and testbench

- Read-side initiator for the backend vector RAM port (en/we/addr/data, 1-cycle read latency, byte-addressed, 64-bit little-endian words).
- Accepts one descriptor at a time: base byte address, word count and byte stride.
- Issues one RAM read per word, buffers returned data and presents it on a valid/ready stream, with last-beat marking and a completion pulse.
- Feeds the vector datapath from RAM that the host side has previously written.

---
 rtl/vec_ram_reader_pkg.sv | 18 +
 rtl/vec_rd_fifo.sv | 70 +++++++
 rtl/vec_ram_reader.sv | 148 ++++++++++++++
 tb/tb_vec_ram_reader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vec_ram_reader_pkg.sv
// Shared constants for the vector RAM reader.
//   BE_ADDR_W / BE_DATA_W / BE_STRB_W : backend RAM port widths
//   VRR_LEN_W                          : default descriptor word-count width
//   vrr_state_e                        : reader FSM encoding
package vec_ram_reader_pkg;

  localparam int BE_ADDR_W = 24;
  localparam int BE_DATA_W = 64;
  localparam int BE_STRB_W = 8;
  localparam int VRR_LEN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } vrr_state_e;

endpackage

// File: rtl/vec_rd_fifo.sv
// First-word-fall-through register FIFO holding returned read words.
//   clk_i, rst_i  : clock, async active-high reset (empties the FIFO)
//   push_i/data_i : write an entry at the tail
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : head entry, valid whenever empty_o is low
//   count_o       : number of stored entries
module vec_rd_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 65,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [W-1:0]     data_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pop_ok;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_ok  = pop_i & (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) begin
      mem_d[wr_q] = data_i;
      wr_d        = nxt(wr_q);
    end
    if (pop_ok) rd_d = nxt(rd_q);
    case ({push_i, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vec_ram_reader.sv
// Read-side initiator for the backend vector RAM port.
// Takes one descriptor (base, len words, byte stride), issues one RAM read
// per word, buffers the 1-cycle-latency returns and streams them out.
//   clk_i, rst_i            : clock, async active-high reset
//   cmd_*                   : descriptor valid/ready + base/len/stride
//   mem_en_o .. mem_d_i     : RAM port (read-only use; we/d tied to 0)
//   m_valid_o .. m_last_o   : output word stream, last marks word len-1
//   busy_o, done_o          : descriptor in progress / 1-cycle completion
module vec_ram_reader
  import vec_ram_reader_pkg::*;
#(
  parameter int ADDR_W    = BE_ADDR_W,
  parameter int DATA_W    = BE_DATA_W,
  parameter int STRB_W    = BE_STRB_W,
  parameter int LEN_W     = VRR_LEN_W,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [ADDR_W-1:0] cmd_base_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic [ADDR_W-1:0] cmd_stride_i,
  output logic              mem_en_o,
  output logic [STRB_W-1:0] mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_d_o,
  input  logic [DATA_W-1:0] mem_d_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  vrr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, stride_q, stride_d;
  logic [LEN_W-1:0]  len_q, len_d, issued_q, issued_d;
  logic [LEN_W-1:0]  rcvd_q, rcvd_d, popped_q, popped_d;
  logic              inflight_q, inflight_d;

  logic              issue, pop, push_last, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occ;
  logic [DATA_W:0]   fifo_head;

  assign pop = m_valid_o & m_ready_i;

  // Buffered + in-flight words, crediting a pop happening this cycle.
  // A new read is only launched if its data is guaranteed a slot.
  assign occ   = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign issue = (state_q == ST_RUN) && (issued_q != len_q) &&
                 (occ < (CNT_W+1)'(BUF_DEPTH));

  // Returned words are tagged with their index so the last flag rides
  // through the buffer alongside the data.
  assign push_last = (rcvd_q == len_q - 1'b1);

  vec_rd_fifo #(
    .DEPTH (BUF_DEPTH),
    .W     (DATA_W + 1),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .data_i  ({push_last, mem_d_i}),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign m_valid_o   = ~fifo_empty;
  assign m_data_o    = fifo_head[DATA_W-1:0];
  assign m_last_o    = m_valid_o & fifo_head[DATA_W];
  assign mem_en_o    = issue;
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = '0;
  assign mem_d_o     = '0;
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    len_d      = len_q;
    issued_d   = issued_q;
    rcvd_d     = rcvd_q;
    popped_d   = popped_q;
    inflight_d = issue;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          addr_d   = cmd_base_i;
          stride_d = cmd_stride_i;
          len_d    = cmd_len_i;
          issued_d = '0;
          rcvd_d   = '0;
          popped_d = '0;
          state_d  = (cmd_len_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          addr_d   = addr_q + stride_q;
          issued_d = issued_q + 1'b1;
        end
        if (inflight_q) rcvd_d = rcvd_q + 1'b1;
        if (pop) begin
          popped_d = popped_q + 1'b1;
          if (popped_q == len_q - 1'b1) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      rcvd_q     <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      rcvd_q     <= rcvd_d;
      popped_q   <= popped_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_vec_ram_reader.sv
module tb_vec_ram_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [23:0] cmd_base_i = '0;
  logic [15:0] cmd_len_i = '0;
  logic [23:0] cmd_stride_i = '0;
  logic        mem_en_o;
  logic [7:0]  mem_we_o;
  logic [23:0] mem_addr_o;
  logic [63:0] mem_d_o;
  logic [63:0] mem_d_i = '0;
  logic        m_valid_o;
  logic        m_ready_i = 1'b1;
  logic [63:0] m_data_o;
  logic        m_last_o;
  logic        busy_o;
  logic        done_o;

  vec_ram_reader dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_base_i(cmd_base_i), .cmd_len_i(cmd_len_i), .cmd_stride_i(cmd_stride_i),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_d_o(mem_d_o), .mem_d_i(mem_d_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_last_o(m_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;
  int cyc = 0, hs_cyc = 0;
  int first_en, first_vld, last_beat, done_cyc;
  int en_cnt, beat_cnt, done_cnt, rd_issued, rd_popped, max_occ;
  bit vld_seen, pat_en = 1'b0;
  logic [23:0] exp_addr[$];
  logic [64:0] exp_beat[$];

  function automatic logic [63:0] ram_word(input logic [23:0] a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = 8'(a + 24'(i));
    return w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic clear_stats();
    first_en = -1; first_vld = -1; last_beat = -1; done_cyc = -1;
    en_cnt = 0; beat_cnt = 0; done_cnt = 0; rd_issued = 0; rd_popped = 0;
    max_occ = 0; vld_seen = 1'b0;
  endtask

  // 1-cycle latency RAM preloaded with address-derived bytes.
  always @(posedge clk) if (mem_en_o) mem_d_i <= ram_word(mem_addr_o);

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every RAM read and every stream beat with the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_issued - rd_popped > max_occ) max_occ = rd_issued - rd_popped;
      if (mem_en_o) begin
        en_cnt++; rd_issued++;
        if (first_en < 0) first_en = cyc;
        if (exp_addr.size() == 0) begin
          n_tot++; $display("FAIL unexpected_read: got addr %h expected none", mem_addr_o);
        end else chk("mem_addr", 64'(mem_addr_o), 64'(exp_addr.pop_front()));
      end
      if (m_valid_o) begin
        vld_seen = 1'b1;
        if (first_vld < 0) first_vld = cyc;
      end
      if (m_valid_o && m_ready_i) begin
        beat_cnt++; rd_popped++; last_beat = cyc;
        if (exp_beat.size() == 0) begin
          n_tot++; $display("FAIL unexpected_beat: got %h expected none", m_data_o);
        end else begin
          logic [64:0] e;
          e = exp_beat.pop_front();
          chk("beat_data", m_data_o, e[63:0]);
          chk("beat_last", 64'(m_last_o), 64'(e[64]));
        end
      end
      if (done_o) begin done_cnt++; done_cyc = cyc; end
    end
  end

  // Backpressure pattern 1,0,0,1 repeating when enabled.
  initial begin
    int k = 0;
    forever begin
      @(posedge clk); #1;
      if (pat_en) begin
        m_ready_i = (k == 0 || k == 3);
        k = (k + 1) % 4;
      end else k = 0;
    end
  end

  task automatic send(input logic [23:0] base, input logic [15:0] len, input logic [23:0] stride);
    for (int i = 0; i < int'(len); i++) begin
      logic [23:0] a;
      a = base + 24'(i) * stride;
      exp_addr.push_back(a);
      exp_beat.push_back({(i == int'(len) - 1), ram_word(a)});
    end
    @(posedge clk); #1;
    cmd_valid_i = 1'b1; cmd_base_i = base; cmd_len_i = len; cmd_stride_i = stride;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0; cmd_base_i = 24'h5A5A5A; cmd_len_i = 16'd7;
    hs_cyc = cyc;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    if (!seen) begin n_tot++; $display("FAIL %s_timeout: no done_o within 200 cycles", nm); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_stats();
    #12;
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("rst_mem_en",    64'(mem_en_o),    64'd0);
    chk("rst_mem_addr",  64'(mem_addr_o),  64'd0);
    chk("rst_m_valid",   64'(m_valid_o),   64'd0);
    chk("rst_m_data",    m_data_o,         64'd0);
    chk("rst_busy_done", {busy_o, done_o, m_last_o}, 3'b000);
    @(posedge clk); #1 rst = 1'b0;

    // Basic contiguous read.
    clear_stats(); m_ready_i = 1'b1;
    send(24'h000010, 16'd4, 24'd8);
    wait_done("basic");
    chk("basic_first_en",  64'(first_en - hs_cyc),   64'd0);
    chk("basic_latency",   64'(first_vld - first_en), 64'd2);
    chk("basic_contig",    64'(last_beat - first_vld), 64'd3);
    chk("basic_done_cyc",  64'(done_cyc - last_beat), 64'd1);
    chk("basic_en_cnt",    64'(en_cnt),   64'd4);
    chk("basic_done_cnt",  64'(done_cnt), 64'd1);

    // Zero-length descriptor.
    clear_stats();
    send(24'h000080, 16'd0, 24'd8);
    wait_done("len0");
    chk("len0_en_cnt",   64'(en_cnt),   64'd0);
    chk("len0_valid",    64'(vld_seen), 64'd0);
    chk("len0_done_cnt", 64'(done_cnt), 64'd1);
    chk("len0_done_lat", 64'(done_cyc >= hs_cyc && done_cyc <= hs_cyc + 1), 64'd1);

    // Backpressure.
    clear_stats(); pat_en = 1'b1;
    send(24'h000300, 16'd8, 24'd8);
    wait_done("bp");
    pat_en = 1'b0; m_ready_i = 1'b1;
    chk("bp_en_cnt",   64'(en_cnt),   64'd8);
    chk("bp_beat_cnt", 64'(beat_cnt), 64'd8);
    chk("bp_max_occ",  64'(max_occ <= 2), 64'd1);
    chk("bp_done_cnt", 64'(done_cnt), 64'd1);

    // Address wrap.
    clear_stats();
    send(24'hFFFFF8, 16'd3, 24'd8);
    wait_done("wrap");
    chk("wrap_en_cnt", 64'(en_cnt), 64'd3);

    // Zero stride.
    clear_stats();
    send(24'h000040, 16'd3, 24'd0);
    wait_done("stride0");
    chk("stride0_beats", 64'(beat_cnt), 64'd3);

    // Asynchronous reset mid-descriptor.
    clear_stats();
    send(24'h000100, 16'd6, 24'd8);
    for (int i = 0; i < 50 && beat_cnt < 2; i++) @(posedge clk);
    if (beat_cnt < 2) begin n_tot++; $display("FAIL rst_mid_timeout: beats %0d expected 2", beat_cnt); end
    #2 rst = 1'b1;
    #1;
    chk("amid_mem_en",    64'(mem_en_o),    64'd0);
    chk("amid_m_valid",   64'(m_valid_o),   64'd0);
    chk("amid_cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("amid_busy_done", {busy_o, done_o, m_last_o, mem_addr_o}, 27'd0);
    exp_addr.delete(); exp_beat.delete();
    @(posedge clk); #3 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("amid_no_done", 64'(done_cnt), 64'd0);

    clear_stats();
    send(24'h000200, 16'd2, 24'd8);
    wait_done("post_rst");
    chk("post_rst_en_cnt", 64'(en_cnt),   64'd2);
    chk("post_rst_beats",  64'(beat_cnt), 64'd2);
    chk("sb_drained",      64'(exp_addr.size() + exp_beat.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
